// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the IF/MEM unified memory arbiter.
// FSM states, owner tags and decoder byte-lane constants.
package riscv_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic [3:0] BYTE_SEL_B = 4'b0001;
  localparam logic [3:0] BYTE_SEL_H = 4'b0011;
  localparam logic [3:0] BYTE_SEL_W = 4'b1111;

endpackage

// File: rtl/riscv_mem_arb_pick.sv
// Winner select between fetch and data requesters.
// Data wins unless fetch has been starved too long.
module riscv_mem_arb_pick
  import riscv_mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   starved,
  output logic   gnt,
  output owner_e own
);

  always_comb begin
    gnt = if_req | dm_req;
    own = OWN_DM;
    unique case (1'b1)
      (if_req & (starved | ~dm_req)): own = OWN_IF;
      (dm_req & ~(if_req & starved)): own = OWN_DM;
      default:                        own = OWN_DM;
    endcase
  end

endmodule

// File: rtl/riscv_mem_arb.sv
// Single-port memory arbiter for IF and MEM requesters.
// Registers the winning request and holds it until the memory acks.
module riscv_mem_arb
  import riscv_mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_ack,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  input  logic [3:0]    i_dm_byte_sel,
  output logic          o_dm_ack,
  output logic [DW-1:0] o_dm_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [3:0]    o_mem_byte_sel,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_err
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e    state_q, state_d;
  owner_e        own_q;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    bsel_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;

  logic   gnt;
  owner_e gnt_own;
  logic   starved;
  logic   tmo_hit;
  logic   arb;

  assign starved = (starve_q == SW'(STARVE_MAX));
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
  assign arb     = (state_q == ARB_IDLE) && gnt;

  riscv_mem_arb_pick u_pick (
    .if_req  (i_if_req),
    .dm_req  (i_dm_req),
    .starved (starved),
    .gnt     (gnt),
    .own     (gnt_own)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (gnt) state_d = ARB_BUSY;
      ARB_BUSY: begin
        if (i_mem_ack)    state_d = ARB_RESP;
        else if (tmo_hit) state_d = ARB_IDLE;
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= ARB_IDLE;
      own_q      <= OWN_IF;
      starve_q   <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bsel_q     <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (arb) begin
        own_q <= gnt_own;
        if (gnt_own == OWN_IF) begin
          we_q    <= 1'b0;
          addr_q  <= i_if_addr;
          wdata_q <= '0;
          bsel_q  <= BYTE_SEL_W;
        end else begin
          we_q    <= i_dm_we;
          addr_q  <= i_dm_addr;
          wdata_q <= i_dm_wdata;
          bsel_q  <= i_dm_byte_sel;
        end
      end
      // starvation only accrues while fetch keeps waiting
      if (state_q == ARB_IDLE) begin
        if (!i_if_req || (gnt && gnt_own == OWN_IF))
          starve_q <= '0;
        else if (gnt && !starved)
          starve_q <= starve_q + SW'(1);
      end
      if (state_q != ARB_BUSY) begin
        tmo_q <= '0;
      end else if (i_mem_ack) begin
        tmo_q <= '0;
        if (own_q == OWN_IF)
          if_rdata_q <= i_mem_rdata;
        else if (!we_q)
          dm_rdata_q <= i_mem_rdata;
      end else begin
        tmo_q <= tmo_q + TW'(1);
        if (tmo_hit)
          err_q <= 1'b1;
      end
    end
  end

  assign o_mem_req      = (state_q == ARB_BUSY);
  assign o_mem_we       = we_q;
  assign o_mem_addr     = addr_q;
  assign o_mem_wdata    = wdata_q;
  assign o_mem_byte_sel = bsel_q;
  assign o_if_ack       = (state_q == ARB_RESP) && (own_q == OWN_IF);
  assign o_dm_ack       = (state_q == ARB_RESP) && (own_q == OWN_DM);
  assign o_if_rdata     = if_rdata_q;
  assign o_dm_rdata     = dm_rdata_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Directed bench for riscv_mem_arb: vector table plus
// starvation, wait-state, timeout and reset sequences.
module tb_riscv_mem_arb;

  logic        clk;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_bsel;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bsel;
  logic        mem_ack;
  logic        mem_ack_m;
  logic        auto_ack;
  logic [31:0] mem_rd;
  logic        err;

  int checks = 0;
  int errors = 0;

  assign mem_ack = auto_ack ? mem_req : mem_ack_m;

  riscv_mem_arb #(
    .AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(8)
  ) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_if_req       (if_req),
    .i_if_addr      (if_addr),
    .o_if_ack       (if_ack),
    .o_if_rdata     (if_rdata),
    .i_dm_req       (dm_req),
    .i_dm_we        (dm_we),
    .i_dm_addr      (dm_addr),
    .i_dm_wdata     (dm_wdata),
    .i_dm_byte_sel  (dm_bsel),
    .o_dm_ack       (dm_ack),
    .o_dm_rdata     (dm_rdata),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_byte_sel (mem_bsel),
    .i_mem_ack      (mem_ack),
    .i_mem_rdata    (mem_rd),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       n;
    logic        ifr, dmr, we, ack;
    logic [31:0] rd;
    logic        e_req, e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_bsel;
    logic        e_ia, e_da;
    logic [31:0] e_ird, e_drd;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    string n, logic ifr, logic dmr, logic we, logic ack,
    logic [31:0] rd, logic e_req, logic e_we, logic [31:0] e_addr,
    logic [3:0] e_bsel, logic e_ia, logic e_da,
    logic [31:0] e_ird, logic [31:0] e_drd);
    vec_t v;
    v.n = n; v.ifr = ifr; v.dmr = dmr; v.we = we; v.ack = ack;
    v.rd = rd; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
    v.e_bsel = e_bsel; v.e_ia = e_ia; v.e_da = e_da;
    v.e_ird = e_ird; v.e_drd = e_drd;
    vq.push_back(v);
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int grants;
  int busy;
  int dacks;
  int iacks;
  int errs;
  logic prev;
  logic seen;

  initial begin
    rstn = 1'b0; if_req = 1'b0; if_addr = 32'h10;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h100;
    dm_wdata = 32'hDEAD_BEEF; dm_bsel = 4'b0011;
    mem_ack_m = 1'b0; auto_ack = 1'b0; mem_rd = '0;

    step(); step();
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.mem_bsel", mem_bsel, 0);
    chk("rst.if_ack", if_ack, 0);
    chk("rst.dm_ack", dm_ack, 0);
    chk("rst.if_rdata", if_rdata, 0);
    chk("rst.dm_rdata", dm_rdata, 0);
    chk("rst.err", err, 0);
    rstn = 1'b1;

    //    name       if dm we ak rdata          req we addr     bsel   ia da ird            drd
    add("f_busy",   1, 0, 0, 0, 32'h0,         1, 0, 32'h10,  4'hF,  0, 0, 32'h0,         32'h0);
    add("f_resp",   1, 0, 0, 1, 32'h13,        0, 0, 32'h10,  4'hF,  1, 0, 32'h13,        32'h0);
    add("f_idle",   1, 0, 0, 0, 32'h0,         0, 0, 32'h10,  4'hF,  0, 0, 32'h13,        32'h0);
    add("f_quiet",  0, 0, 0, 0, 32'h0,         0, 0, 32'h10,  4'hF,  0, 0, 32'h13,        32'h0);
    add("both_st",  1, 1, 1, 0, 32'h0,         1, 1, 32'h100, 4'h3,  0, 0, 32'h13,        32'h0);
    add("st_resp",  1, 1, 1, 1, 32'h55,        0, 1, 32'h100, 4'h3,  0, 1, 32'h13,        32'h0);
    add("st_idle",  1, 1, 1, 0, 32'h0,         0, 1, 32'h100, 4'h3,  0, 0, 32'h13,        32'h0);
    add("f2_busy",  1, 0, 0, 0, 32'h0,         1, 0, 32'h10,  4'hF,  0, 0, 32'h13,        32'h0);
    add("f2_resp",  1, 0, 0, 1, 32'h93,        0, 0, 32'h10,  4'hF,  1, 0, 32'h93,        32'h0);
    add("f2_idle",  1, 0, 0, 0, 32'h0,         0, 0, 32'h10,  4'hF,  0, 0, 32'h93,        32'h0);
    add("ld_busy",  0, 1, 0, 0, 32'h0,         1, 0, 32'h100, 4'h3,  0, 0, 32'h93,        32'h0);
    add("ld_resp",  0, 1, 0, 1, 32'hCAFE_F00D, 0, 0, 32'h100, 4'h3,  0, 1, 32'h93,        32'hCAFE_F00D);
    add("ld_idle",  0, 1, 0, 0, 32'h0,         0, 0, 32'h100, 4'h3,  0, 0, 32'h93,        32'hCAFE_F00D);
    add("ld_quiet", 0, 0, 0, 0, 32'h0,         0, 0, 32'h100, 4'h3,  0, 0, 32'h93,        32'hCAFE_F00D);

    foreach (vq[i]) begin
      if_req = vq[i].ifr; dm_req = vq[i].dmr; dm_we = vq[i].we;
      mem_ack_m = vq[i].ack; mem_rd = vq[i].rd;
      step();
      chk({vq[i].n, ".req"}, mem_req, vq[i].e_req);
      chk({vq[i].n, ".we"}, mem_we, vq[i].e_we);
      chk({vq[i].n, ".addr"}, mem_addr, vq[i].e_addr);
      chk({vq[i].n, ".bsel"}, mem_bsel, vq[i].e_bsel);
      chk({vq[i].n, ".if_ack"}, if_ack, vq[i].e_ia);
      chk({vq[i].n, ".dm_ack"}, dm_ack, vq[i].e_da);
      chk({vq[i].n, ".if_rd"}, if_rdata, vq[i].e_ird);
      chk({vq[i].n, ".dm_rd"}, dm_rdata, vq[i].e_drd);
      chk({vq[i].n, ".err"}, err, 0);
    end
    chk("store.wdata", mem_wdata, 32'hDEAD_BEEF);

    // both requesting continuously: D D D D F repeating
    mem_ack_m = 1'b0; mem_rd = '0; auto_ack = 1'b1;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
    grants = 0; prev = 1'b0;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      step();
      if (mem_req && !prev) begin
        chk($sformatf("starve.g%0d", grants), mem_addr,
            (grants % 5 == 4) ? 32'h10 : 32'h100);
        grants++;
      end
      prev = mem_req;
    end
    chk("starve.count", grants, 10);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (4) step();
    auto_ack = 1'b0;
    chk("starve.idle", mem_req, 0);

    // three memory wait cycles on a fetch
    if_req = 1'b1; mem_ack_m = 1'b0; iacks = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("wait.req%0d", k), mem_req, 1);
      chk($sformatf("wait.addr%0d", k), mem_addr, 32'h10);
      if (if_ack) iacks++;
      mem_ack_m = (k == 3);
      mem_rd = 32'h77;
    end
    step();
    chk("wait.ack", if_ack, 1);
    chk("wait.rdata", if_rdata, 32'h77);
    chk("wait.req_off", mem_req, 0);
    if (if_ack) iacks++;
    if_req = 1'b0; mem_ack_m = 1'b0;
    repeat (2) begin
      step();
      if (if_ack) iacks++;
    end
    chk("wait.ack_count", iacks, 1);

    // memory never acks: abort after 8 busy cycles
    dm_req = 1'b1; dm_we = 1'b0; mem_ack_m = 1'b0;
    step();
    busy = 0; dacks = 0; errs = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (mem_req) busy++;
      if (dm_ack) dacks++;
      if (err) begin
        seen = 1'b1;
        errs++;
        chk("tmo.busy_cycles", busy, 8);
        chk("tmo.req_in_err", mem_req, 0);
      end else begin
        step();
      end
    end
    chk("tmo.seen", seen, 1);
    step();
    if (err) errs++;
    if (dm_ack) dacks++;
    chk("tmo.err_count", errs, 1);
    chk("tmo.no_ack", dacks, 0);
    chk("tmo.regrant", mem_req, 1);
    chk("tmo.regrant_addr", mem_addr, 32'h100);

    // reset while busy aborts the access
    rstn = 1'b0; mem_ack_m = 1'b1; mem_rd = 32'h1234_5678;
    step();
    chk("rbusy.mem_req", mem_req, 0);
    chk("rbusy.mem_addr", mem_addr, 0);
    chk("rbusy.mem_bsel", mem_bsel, 0);
    chk("rbusy.dm_ack", dm_ack, 0);
    chk("rbusy.if_ack", if_ack, 0);
    chk("rbusy.dm_rdata", dm_rdata, 0);
    chk("rbusy.if_rdata", if_rdata, 0);
    chk("rbusy.err", err, 0);
    rstn = 1'b1; dm_req = 1'b0; mem_ack_m = 1'b0;
    dacks = 0;
    repeat (3) begin
      step();
      if (dm_ack || mem_req) dacks++;
    end
    chk("rbusy.quiet_after", dacks, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
